// File: rtl/ysyx_22050058_pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_22050058_pipe_ctrl_if
//  Description : Bundle of pipeline request inputs and control outputs for
//                the pipeline stall/flush controller. The master side raises
//                stage requests. The slave side is the controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ysyx_22050058_pipe_ctrl_if #(
    parameter int STAGES = 6,
    parameter int CNT_W  = 32
);
    // Requests from the pipeline stages and the commit logic
    logic [STAGES-1:0] stall_req_i;
    logic [STAGES-1:0] flush_req_i;
    logic              trap_req_i;
    logic              trap_done_i;

    // Controls and status from the controller
    logic [STAGES-1:0] stall;
    logic [STAGES-1:0] flush;
    logic [1:0]        state_o;
    logic [CNT_W-1:0]  stall_cnt_o;
    logic [CNT_W-1:0]  flush_cnt_o;

    // Pipeline / requester side
    modport master (
        output stall_req_i,
        output flush_req_i,
        output trap_req_i,
        output trap_done_i,
        input  stall,
        input  flush,
        input  state_o,
        input  stall_cnt_o,
        input  flush_cnt_o
    );

    // Controller side
    modport slave (
        input  stall_req_i,
        input  flush_req_i,
        input  trap_req_i,
        input  trap_done_i,
        output stall,
        output flush,
        output state_o,
        output stall_cnt_o,
        output flush_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/ysyx_22050058_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_22050058_pipe_ctrl
//  Description : Pipeline hazard controller. It builds the per-stage stall
//                and flush masks from the stage requests. It defers
//                redirects that a stall on an older stage blocks, and holds
//                flushes for a configurable number of cycles. It sequences
//                trap entry. It also keeps stall and flush event counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22050058_pipe_ctrl #(
    parameter int STAGES     = 6,
    parameter int FLUSH_HOLD = 1,
    parameter int CNT_W      = 32
) (
    input wire clk,
    input wire rst,
    ysyx_22050058_pipe_ctrl_if.slave bus
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int                c_HOLD_W    = 4;
    localparam logic [c_HOLD_W-1:0] c_HOLD_INIT = c_HOLD_W'(FLUSH_HOLD - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_ONE  = c_HOLD_W'(1);
    localparam logic [STAGES-1:0] c_ALL_ONES  = {STAGES{1'b1}};
    localparam logic [STAGES-1:0] c_FETCH_BIT = {{(STAGES-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  c_CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  c_CNT_MAX   = {CNT_W{1'b1}};
    localparam bit                c_USE_HOLD  = (FLUSH_HOLD > 1);

    // Controller states; the encoding is visible on state_o
    typedef enum logic [1:0] {
        c_ST_RUN   = 2'b00,
        c_ST_FLUSH = 2'b01,
        c_ST_TRAP  = 2'b10
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t               state_q,     state_d;
    logic [STAGES-1:0]    pend_q,      pend_d;       // deferred redirect mask, 0 = none
    logic [STAGES-1:0]    hold_mask_q, hold_mask_d;  // mask replayed while in FLUSH
    logic [c_HOLD_W-1:0]  hold_cnt_q,  hold_cnt_d;   // FLUSH cycles still to go
    logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]     flush_cnt_q, flush_cnt_d;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic [STAGES-1:0] w_stall_fill;   // bits [j:0], j = highest stall request
    logic [STAGES-1:0] w_new_mask;     // bits [k-1:0], k = highest redirect
    logic [STAGES-1:0] w_cand;         // redirect mask competing this cycle
    logic [STAGES-1:0] w_stall;
    logic [STAGES-1:0] w_flush;
    logic              w_flush_evt;    // applied redirect or trap entry

    // A stage stalls when it or any younger-indexed... older stage requests it:
    // every stage at or below the highest requester must hold.
    generate
        for (genvar i = 0; i < STAGES; i++) begin : g_stall_fill
            assign w_stall_fill[i] = |bus.stall_req_i[STAGES-1:i];
        end
    endgenerate

    // A redirect at stage k squashes every stage below it. A redirect
    // reported by stage 0 alone squashes nothing.
    generate
        for (genvar i = 0; i < STAGES; i++) begin : g_flush_fill
            if (i == STAGES - 1) begin : g_top
                assign w_new_mask[i] = 1'b0;
            end else begin : g_low
                assign w_new_mask[i] = |bus.flush_req_i[STAGES-1:i+1];
            end
        end
    endgenerate

    // Thermometer masks compare like indices: the larger mask is the older
    // redirect, so it takes priority over a pending one.
    assign w_cand = (w_new_mask > pend_q) ? w_new_mask : pend_q;

    // Next-state and output decode for the controller FSM
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        hold_mask_d = hold_mask_q;
        hold_cnt_d  = hold_cnt_q;
        w_stall     = w_stall_fill;
        w_flush     = '0;
        w_flush_evt = 1'b0;

        case (state_q)
            c_ST_RUN: begin
                if (bus.trap_req_i) begin
                    w_flush     = c_ALL_ONES;
                    w_flush_evt = 1'b1;
                    pend_d      = '0;
                    hold_mask_d = '0;
                    hold_cnt_d  = '0;
                    state_d     = c_ST_TRAP;
                end else if (|w_cand) begin
                    // ~w_cand selects the stages at or above the redirect
                    // point. A stall there means the redirect must wait.
                    if (|(bus.stall_req_i & ~w_cand)) begin
                        pend_d = w_cand;
                    end else begin
                        w_flush     = w_cand;
                        w_flush_evt = 1'b1;
                        pend_d      = '0;
                        if (c_USE_HOLD) begin
                            state_d     = c_ST_FLUSH;
                            hold_mask_d = w_cand;
                            hold_cnt_d  = c_HOLD_INIT;
                        end
                    end
                end
            end

            c_ST_FLUSH: begin
                if (bus.trap_req_i) begin
                    w_flush     = c_ALL_ONES;
                    w_flush_evt = 1'b1;
                    pend_d      = '0;
                    hold_mask_d = '0;
                    hold_cnt_d  = '0;
                    state_d     = c_ST_TRAP;
                end else if (w_new_mask > hold_mask_q) begin
                    // An older redirect widens the flush and restarts the hold
                    w_flush     = w_new_mask;
                    w_flush_evt = 1'b1;
                    hold_mask_d = w_new_mask;
                    hold_cnt_d  = c_HOLD_INIT;
                end else begin
                    w_flush = hold_mask_q;
                    if (hold_cnt_q <= c_HOLD_ONE) begin
                        hold_cnt_d  = '0;
                        hold_mask_d = '0;
                        state_d     = c_ST_RUN;
                    end else begin
                        hold_cnt_d = hold_cnt_q - c_HOLD_ONE;
                    end
                end
            end

            c_ST_TRAP: begin
                // The whole pipe is frozen until the handler PC is known.
                // Then fetch alone is bubbled as the pipe restarts.
                w_stall = c_ALL_ONES;
                if (bus.trap_done_i) begin
                    w_flush = c_FETCH_BIT;
                    state_d = c_ST_RUN;
                end
            end

            default: begin
                w_stall     = '0;
                pend_d      = '0;
                hold_mask_d = '0;
                hold_cnt_d  = '0;
                state_d     = c_ST_RUN;
            end
        endcase
    end

    // Stall counter saturates. The flush counter wraps.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (|w_stall && (stall_cnt_q != c_CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + c_CNT_ONE;
        end
        if (w_flush_evt) begin
            flush_cnt_d = flush_cnt_q + c_CNT_ONE;
        end
    end

    // State register with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= c_ST_RUN;
            pend_q      <= '0;
            hold_mask_q <= '0;
            hold_cnt_q  <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            hold_mask_q <= hold_mask_d;
            hold_cnt_q  <= hold_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Controls are forced quiet while reset is held
    assign bus.stall       = rst ? '0 : w_stall;
    assign bus.flush       = rst ? '0 : w_flush;
    assign bus.state_o     = state_q;
    assign bus.stall_cnt_o = stall_cnt_q;
    assign bus.flush_cnt_o = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050058_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ysyx_22050058_pipe_ctrl
//  Description : Self-checking bench for the pipeline controller. It uses
//                directed scenarios followed by random traffic. Each case
//                is checked against an index-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_22050058_pipe_ctrl;

    localparam int          STAGES = 6;
    localparam int          FH     = 3;
    localparam int          CW     = 4;
    localparam logic [5:0]  ALL    = 6'h3f;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ysyx_22050058_pipe_ctrl_if #(.STAGES(STAGES), .CNT_W(CW)) bus ();

    ysyx_22050058_pipe_ctrl #(
        .STAGES    (STAGES),
        .FLUSH_HOLD(FH),
        .CNT_W     (CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0 RUN, 1 FLUSH, 2 TRAP. Redirects are held as
    // stage indices (0 = none). Counters are plain integers.
    int m_mode, m_pend, m_hold_k, m_hold_left, m_scnt, m_fcnt;

    logic [5:0] last_stall, last_flush;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int hi(input logic [5:0] v);
        for (int i = 5; i >= 0; i--) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [5:0] lowmask(input int n);
        logic [6:0] t;
        if (n <= 0) return 6'd0;
        t = (7'd1 << n) - 7'd1;
        return t[5:0];
    endfunction

    task automatic model_reset();
        m_mode = 0; m_pend = 0; m_hold_k = 0; m_hold_left = 0;
        m_scnt = 0; m_fcnt = 0;
    endtask

    // One clock cycle: drive, check registered status, predict and check
    // the combinational controls, then advance the model across the edge.
    task automatic step(input logic [5:0] sr, input logic [5:0] fr,
                        input logic tr, input logic td);
        int j, k, cand;
        logic [5:0] es, ef;
        bus.stall_req_i = sr;
        bus.flush_req_i = fr;
        bus.trap_req_i  = tr;
        bus.trap_done_i = td;
        #1;
        check("state", {30'd0, bus.state_o}, m_mode);
        check("stall_cnt", {28'd0, bus.stall_cnt_o}, m_scnt);
        check("flush_cnt", {28'd0, bus.flush_cnt_o}, m_fcnt);

        j  = hi(sr);
        k  = hi(fr);
        es = lowmask(j + 1);
        ef = 6'd0;
        if (m_mode == 2) begin
            es = ALL;
            if (td) begin
                ef = 6'd1;
                m_mode = 0;
            end
        end else if (tr) begin
            ef = ALL;
            m_fcnt = (m_fcnt + 1) % 16;
            m_pend = 0; m_hold_k = 0; m_hold_left = 0;
            m_mode = 2;
        end else if (m_mode == 0) begin
            cand = m_pend;
            if (k >= 1 && k > cand) cand = k;
            if (cand > 0) begin
                if (j >= cand) begin
                    m_pend = cand;
                end else begin
                    ef = lowmask(cand);
                    m_fcnt = (m_fcnt + 1) % 16;
                    m_pend = 0;
                    m_mode = 1; m_hold_k = cand; m_hold_left = FH - 1;
                end
            end
        end else begin
            if (k > m_hold_k) begin
                ef = lowmask(k);
                m_fcnt = (m_fcnt + 1) % 16;
                m_hold_k = k; m_hold_left = FH - 1;
            end else begin
                ef = lowmask(m_hold_k);
                m_hold_left--;
                if (m_hold_left == 0) begin
                    m_mode = 0; m_hold_k = 0;
                end
            end
        end
        if (es != 6'd0 && m_scnt < 15) m_scnt++;

        last_stall = bus.stall;
        last_flush = bus.flush;
        check("stall", {26'd0, bus.stall}, {26'd0, es});
        check("flush", {26'd0, bus.flush}, {26'd0, ef});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(6'd0, 6'd0, 1'b0, 1'b0);
    endtask

    // Reset is asserted mid-cycle. Controls must drop at once, and all
    // status must clear before the next clock edge.
    task automatic do_reset();
        rst = 1'b1;
        bus.stall_req_i = 6'($urandom);
        bus.flush_req_i = 6'($urandom);
        bus.trap_req_i  = 1'b1;
        bus.trap_done_i = 1'b1;
        #1;
        check("rst_stall", {26'd0, bus.stall}, 32'd0);
        check("rst_flush", {26'd0, bus.flush}, 32'd0);
        check("rst_state", {30'd0, bus.state_o}, 32'd0);
        check("rst_scnt", {28'd0, bus.stall_cnt_o}, 32'd0);
        check("rst_fcnt", {28'd0, bus.flush_cnt_o}, 32'd0);
        @(posedge clk);
        #1;
        check("rst_hold_flush", {26'd0, bus.flush}, 32'd0);
        rst = 1'b0;
        model_reset();
    endtask

    // Directed scenarios followed by random traffic
    initial begin
        bus.stall_req_i = '0;
        bus.flush_req_i = '0;
        bus.trap_req_i  = 1'b0;
        bus.trap_done_i = 1'b0;
        model_reset();
        #1;
        do_reset();

        // Stall fill from the highest requester down
        step(6'b000100, 6'd0, 1'b0, 1'b0);
        check("cov_stall_a", {26'd0, last_stall}, 32'b000111);
        step(6'b010100, 6'd0, 1'b0, 1'b0);
        check("cov_stall_b", {26'd0, last_stall}, 32'b011111);
        check("cov_stall_cnt", {28'd0, bus.stall_cnt_o}, 32'd2);

        // Unblocked redirect with a three-cycle flush
        step(6'd0, 6'b001000, 1'b0, 1'b0);
        check("cov_flush_c0", {26'd0, last_flush}, 32'b000111);
        check("cov_flush_cnt", {28'd0, bus.flush_cnt_o}, 32'd1);
        check("cov_flush_st", {30'd0, bus.state_o}, 32'd1);
        step(6'd0, 6'd0, 1'b0, 1'b0);
        check("cov_flush_c1", {26'd0, last_flush}, 32'b000111);
        step(6'd0, 6'd0, 1'b0, 1'b0);
        check("cov_flush_c2", {26'd0, last_flush}, 32'b000111);
        check("cov_flush_back", {30'd0, bus.state_o}, 32'd0);
        idle(1);

        // Redirect deferred behind an older-stage stall
        step(6'b010000, 6'b001000, 1'b0, 1'b0);
        check("cov_defer_0", {26'd0, last_flush}, 32'd0);
        step(6'b010000, 6'd0, 1'b0, 1'b0);
        check("cov_defer_1", {26'd0, last_flush}, 32'd0);
        step(6'd0, 6'd0, 1'b0, 1'b0);
        check("cov_defer_go", {26'd0, last_flush}, 32'b000111);
        idle(3);

        // Oldest redirect wins
        step(6'd0, 6'b010100, 1'b0, 1'b0);
        check("cov_oldest", {26'd0, last_flush}, 32'b001111);
        // A higher redirect restarts the hold while in FLUSH
        step(6'd0, 6'b100000, 1'b0, 1'b0);
        check("cov_restart", {26'd0, last_flush}, 32'b011111);
        idle(3);

        // Trap during FLUSH, then handler entry
        step(6'd0, 6'b001000, 1'b0, 1'b0);
        step(6'b000011, 6'd0, 1'b1, 1'b0);
        check("cov_trap_flush", {26'd0, last_flush}, 32'b111111);
        check("cov_trap_state", {30'd0, bus.state_o}, 32'd2);
        for (int i = 0; i < 3; i++) step(6'($urandom), 6'($urandom), 1'($urandom), 1'b0);
        check("cov_trap_stall", {26'd0, last_stall}, 32'b111111);
        step(6'd0, 6'd0, 1'b0, 1'b1);
        check("cov_trap_done", {26'd0, last_flush}, 32'b000001);
        check("cov_trap_run", {30'd0, bus.state_o}, 32'd0);

        // Reset while in TRAP; no flush cycle afterwards
        step(6'd0, 6'd0, 1'b1, 1'b0);
        step(6'd0, 6'd0, 1'b0, 1'b0);
        do_reset();
        step(6'd0, 6'd0, 1'b0, 1'b1);
        check("cov_rst_trap", {26'd0, last_flush}, 32'd0);

        // Saturating stall counter
        do_reset();
        for (int i = 0; i < 17; i++) step(6'b000001, 6'd0, 1'b0, 1'b0);
        check("cov_sat", {28'd0, bus.stall_cnt_o}, 32'd15);

        // Wrapping flush counter
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(6'd0, 6'b000010, 1'b0, 1'b0);
            idle(2);
            if (i == 14) check("cov_fcnt_15", {28'd0, bus.flush_cnt_o}, 32'd15);
        end
        check("cov_wrap", {28'd0, bus.flush_cnt_o}, 32'd0);

        // Random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            logic [5:0] sr, fr;
            logic tr, td;
            sr = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
            fr = ($urandom_range(0, 3) == 0) ? 6'(1 << $urandom_range(0, 5)) : 6'd0;
            if ($urandom_range(0, 7) == 0) fr = fr | 6'($urandom);
            tr = ($urandom_range(0, 24) == 0);
            td = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 199) == 0) do_reset();
            else step(sr, fr, tr, td);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
